// File: rtl/simple_mips.sv
// Single-cycle word-addressed toy MIPS core: writable IM, 32x32 register file, ALU (ADD/ADDI/SUB/DIV).
// Latency: one instruction per clock; write-back and debug trace registered on the executing edge.
// Backpressure: im_write=1 stalls the core (PC/registers hold, dbg_wb_en=0); IM writes proceed even in reset.
module simple_mips #(
  parameter int IM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        im_write,
  input  logic [31:0] im_addr,
  input  logic [31:0] im_wdata,
  output logic [31:0] dbg_pc,
  output logic        dbg_wb_en,
  output logic [4:0]  dbg_wb_reg,
  output logic [31:0] dbg_wb_data
);

  localparam int AW = $clog2(IM_DEPTH);

  localparam logic [5:0] OP_ADD  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_SUB  = 6'd5;
  localparam logic [5:0] OP_DIV  = 6'd6;

  logic [31:0]   im [IM_DEPTH];
  logic [31:0]   rf [32];
  logic [AW-1:0] pc;

  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        in_range;

  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  assign in_range = (im_addr < 32'(IM_DEPTH));

  // IM write port: not reset, out-of-range addresses are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (im_write && in_range) begin
      im[im_addr[AW-1:0]] <= im_wdata;
    end
  end

  assign instr    = im[pc];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : rf[rt];

  // Decode and ALU; writes aimed at r0 are squashed here so they never reach the trace.
  always_comb begin
    wr_en   = 1'b0;
    wr_reg  = 5'd0;
    wr_data = 32'd0;
    case (op)
      OP_ADD: begin
        wr_en   = 1'b1;
        wr_reg  = rd;
        wr_data = rs_val + rt_val;
      end
      OP_ADDI: begin
        wr_en   = 1'b1;
        wr_reg  = rt;
        wr_data = rs_val + imm_sext;
      end
      OP_SUB: begin
        wr_en   = 1'b1;
        wr_reg  = rd;
        wr_data = rs_val - rt_val;
      end
      OP_DIV: begin
        wr_en   = 1'b1;
        wr_reg  = rd;
        wr_data = (rt_val == 32'd0) ? 32'hFFFF_FFFF : (rs_val / rt_val);
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
    if (wr_reg == 5'd0) begin
      wr_en = 1'b0;
    end
  end

  // Architectural state and debug trace: hold on stall, commit and advance PC on execute.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= '0;
      dbg_wb_en   <= 1'b0;
      dbg_wb_reg  <= 5'd0;
      dbg_wb_data <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= 32'd0;
      end
    end else if (im_write) begin
      dbg_wb_en <= 1'b0;
    end else begin
      pc <= pc + AW'(1);
      if (wr_en) begin
        rf[wr_reg]  <= wr_data;
        dbg_wb_en   <= 1'b1;
        dbg_wb_reg  <= wr_reg;
        dbg_wb_data <= wr_data;
      end else begin
        dbg_wb_en <= 1'b0;
      end
    end
  end

  assign dbg_pc = 32'(pc);

endmodule

// File: tb/tb_simple_mips.sv
// Directed bench for simple_mips: load, execute, divide-by-zero, r0, wrap, mid-run reset.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: exercises the im_write stall during program load.
module tb_simple_mips;

  logic        clk;
  logic        rstn;
  logic        im_write;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic [31:0] dbg_pc;
  logic        dbg_wb_en;
  logic [4:0]  dbg_wb_reg;
  logic [31:0] dbg_wb_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [64];
  logic        exp_en   [13];
  logic [4:0]  exp_reg  [13];
  logic [31:0] exp_data [13];

  simple_mips #(.IM_DEPTH(64)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .im_write   (im_write),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .dbg_pc     (dbg_pc),
    .dbg_wb_en  (dbg_wb_en),
    .dbg_wb_reg (dbg_wb_reg),
    .dbg_wb_data(dbg_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case something stalls the run unexpectedly.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_tables();
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[1]  = itype(6'd4, 5'd0, 5'd1, 16'd178);
    prog[2]  = itype(6'd4, 5'd0, 5'd2, 16'd12);
    prog[3]  = rtype(6'd3, 5'd1, 5'd2, 5'd3);
    prog[4]  = rtype(6'd5, 5'd1, 5'd2, 5'd4);
    prog[5]  = itype(6'd4, 5'd1, 5'd5, 16'd0);
    prog[6]  = rtype(6'd6, 5'd5, 5'd2, 5'd5);
    prog[7]  = rtype(6'd6, 5'd5, 5'd2, 5'd5);
    prog[8]  = rtype(6'd6, 5'd5, 5'd2, 5'd5);
    prog[9]  = rtype(6'd6, 5'd5, 5'd0, 5'd5);
    prog[10] = itype(6'd4, 5'd0, 5'd1, 16'hFFFF);
    prog[11] = rtype(6'd3, 5'd1, 5'd2, 5'd0);
    prog[12] = rtype(6'd63, 5'd1, 5'd2, 5'd3);
    prog[36] = itype(6'd4, 5'd0, 5'd7, 16'd36);
    // Expected trace after executing IM[i]; non-writing cycles hold reg/data.
    exp_en[0]  = 1'b0; exp_reg[0]  = 5'd0; exp_data[0]  = 32'd0;
    exp_en[1]  = 1'b1; exp_reg[1]  = 5'd1; exp_data[1]  = 32'd178;
    exp_en[2]  = 1'b1; exp_reg[2]  = 5'd2; exp_data[2]  = 32'd12;
    exp_en[3]  = 1'b1; exp_reg[3]  = 5'd3; exp_data[3]  = 32'd190;
    exp_en[4]  = 1'b1; exp_reg[4]  = 5'd4; exp_data[4]  = 32'd166;
    exp_en[5]  = 1'b1; exp_reg[5]  = 5'd5; exp_data[5]  = 32'd178;
    exp_en[6]  = 1'b1; exp_reg[6]  = 5'd5; exp_data[6]  = 32'd14;
    exp_en[7]  = 1'b1; exp_reg[7]  = 5'd5; exp_data[7]  = 32'd1;
    exp_en[8]  = 1'b1; exp_reg[8]  = 5'd5; exp_data[8]  = 32'd0;
    exp_en[9]  = 1'b1; exp_reg[9]  = 5'd5; exp_data[9]  = 32'hFFFF_FFFF;
    exp_en[10] = 1'b1; exp_reg[10] = 5'd1; exp_data[10] = 32'hFFFF_FFFF;
    exp_en[11] = 1'b0; exp_reg[11] = 5'd1; exp_data[11] = 32'hFFFF_FFFF;
    exp_en[12] = 1'b0; exp_reg[12] = 5'd1; exp_data[12] = 32'hFFFF_FFFF;
  endtask

  // Reset state, and an IM write issued while reset is held.
  task automatic test_reset();
    rstn     = 1'b0;
    im_write = 1'b1;
    im_addr  = 32'd1;
    im_wdata = prog[1];
    tick();
    tick();
    checks++;
    if (dbg_pc !== 32'd0 || dbg_wb_en !== 1'b0 || dbg_wb_reg !== 5'd0 || dbg_wb_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: pc=%h en=%b reg=%0d data=%h, required all zero",
               dbg_pc, dbg_wb_en, dbg_wb_reg, dbg_wb_data);
    end
  endtask

  // Load the rest of IM with the core stalled; trace must stay quiet.
  task automatic test_load();
    rstn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i != 1) begin
        im_write = 1'b1;
        im_addr  = 32'(i);
        im_wdata = prog[i];
        tick();
        checks++;
        if (dbg_pc !== 32'd0 || dbg_wb_en !== 1'b0) begin
          errors++;
          $display("FAIL load_stall[%0d]: pc=%h en=%b, required pc=0 en=0", i, dbg_pc, dbg_wb_en);
        end
      end
    end
    // Out-of-range write that would alias onto IM[36] if the address were truncated.
    im_addr  = 32'd100;
    im_wdata = itype(6'd4, 5'd0, 5'd6, 16'd77);
    tick();
    checks++;
    if (dbg_pc !== 32'd0 || dbg_wb_en !== 1'b0) begin
      errors++;
      $display("FAIL load_stall_oor: pc=%h en=%b, required pc=0 en=0", dbg_pc, dbg_wb_en);
    end
    im_write = 1'b0;
    im_addr  = 32'd0;
    im_wdata = 32'd0;
  endtask

  // Execute IM[0..12]: arithmetic, divide chain, div-by-zero, negative imm, r0 write, opcode 63.
  task automatic test_program();
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (dbg_pc !== 32'(i + 1) || dbg_wb_en !== exp_en[i] ||
          dbg_wb_reg !== exp_reg[i] || dbg_wb_data !== exp_data[i]) begin
        errors++;
        $display("FAIL exec[%0d]: pc=%h en=%b reg=%0d data=%h, required pc=%h en=%b reg=%0d data=%h",
                 i, dbg_pc, dbg_wb_en, dbg_wb_reg, dbg_wb_data,
                 32'(i + 1), exp_en[i], exp_reg[i], exp_data[i]);
      end
    end
  endtask

  // Run the remaining NOP space through the 63->0 wrap; IM[36] must still hold its own instruction.
  task automatic test_wrap();
    for (int i = 13; i < 64; i++) begin
      tick();
      checks++;
      if (dbg_pc !== 32'((i + 1) % 64) || dbg_wb_en !== (i == 36)) begin
        errors++;
        $display("FAIL wrap_pc[%0d]: pc=%h en=%b, required pc=%h en=%b",
                 i, dbg_pc, dbg_wb_en, 32'((i + 1) % 64), (i == 36));
      end
      if (i == 36) begin
        checks++;
        if (dbg_wb_reg !== 5'd7 || dbg_wb_data !== 32'd36) begin
          errors++;
          $display("FAIL oor_write_dropped: reg=%0d data=%h, required reg=7 data=%h",
                   dbg_wb_reg, dbg_wb_data, 32'd36);
        end
      end
    end
  endtask

  // Async reset mid-run, then re-execute from IM[0].
  task automatic test_reset_mid();
    tick();
    tick();
    tick();
    checks++;
    if (dut.rf[2] !== 32'd12 || dbg_pc !== 32'd3) begin
      errors++;
      $display("FAIL pre_reset_state: r2=%h pc=%h, required r2=%h pc=%h", dut.rf[2], dbg_pc, 32'd12, 32'd3);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (dbg_pc !== 32'd0 || dbg_wb_en !== 1'b0 || dbg_wb_data !== 32'd0 ||
        dut.rf[1] !== 32'd0 || dut.rf[2] !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: pc=%h en=%b data=%h r1=%h r2=%h, required all zero",
               dbg_pc, dbg_wb_en, dbg_wb_data, dut.rf[1], dut.rf[2]);
    end
    tick();
    checks++;
    if (dbg_pc !== 32'd0 || dbg_wb_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge_commit: pc=%h en=%b, required pc=0 en=0", dbg_pc, dbg_wb_en);
    end
    rstn = 1'b1;
    test_program();
  endtask

  initial begin
    rstn     = 1'b0;
    im_write = 1'b0;
    im_addr  = 32'd0;
    im_wdata = 32'd0;
    build_tables();
    test_reset();
    test_load();
    test_program();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
